// File: rtl/bank_sched_stats_pkg.sv
// Shared types and helpers for the per-bank latency monitor.
// Provides the outstanding-request entry struct, latency saturation,
// histogram bin selection and the CSV trace header text.
// The entry struct is sized by ENTRY_ID_W / ENTRY_CYC_W. The monitor's
// ID_W / CYC_W must not exceed these widths.
package bank_sched_stats_pkg;

  localparam int unsigned ENTRY_ID_W  = 32;
  localparam int unsigned ENTRY_CYC_W = 64;

  // One outstanding request tracked by the monitor
  typedef struct packed {
    logic                   valid;
    logic [ENTRY_ID_W-1:0]  id;
    logic                   is_write;
    logic [ENTRY_CYC_W-1:0] start;
  } bsm_entry_t;

  // Header row of the optional simulation trace file
  localparam CSV_HEADER = "RequestID,Type,StartCycle,EndCycle,Latency";

  // Clamp a raw cycle difference to the largest lat_w-bit value
  function automatic logic [63:0] sat_latency(input logic [63:0] diff,
                                              input int unsigned lat_w);
    logic [63:0] lim;
    if (lat_w >= 64) return diff;
    lim = (64'd1 << lat_w) - 64'd1;
    return (diff > lim) ? lim : diff;
  endfunction

  // Histogram bin: latency / 2^shift, with everything past the end in the last bin
  function automatic logic [31:0] bin_index(input logic [63:0] lat,
                                            input int unsigned shift,
                                            input int unsigned nbins);
    logic [63:0] b;
    b = lat >> shift;
    if (b >= 64'(nbins)) return 32'(nbins - 1);
    return 32'(b);
  endfunction

endpackage

// File: rtl/bsm_lowest_index.sv
// Lowest-set-bit encoder.
// Ports: i_vec    request vector (bit i set = candidate i)
//        o_idx_c  index of the lowest set bit (0 when none set)
//        o_found_c at least one bit of i_vec is set
module bsm_lowest_index #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx_c,
  output logic         o_found_c
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    o_idx_c   = '0;
    o_found_c = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx_c   = W'(i);
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_sched_latency_monitor.sv
// Per-bank scheduler latency monitor.
// Tracks accepted requests in a NUM_TAGS-entry table, matches completions by
// ID, and accumulates latency statistics (min/max/sum, per-type completion
// counts, histogram, drop and orphan counts).
// Ports: clk, reset_n (async active-low)
//        req_fire/rd_en/wr_en/request_id : request accepted this cycle
//        resp_fire/resp_id               : request completed this cycle
//        globalCycle                     : free-running cycle count
//        clear_stats                     : synchronous statistics clear
//        occupancy/table_full            : table state
//        lat_valid/lat_value/lat_is_write: per-completion pulse
//        rd_done_cnt..hist               : accumulated statistics
// Optional macro STATS_CSV_TRACE_EN adds a simulation-only CSV trace.
module bank_sched_latency_monitor
  import bank_sched_stats_pkg::*;
#(
  parameter int          RANK      = 0,
  parameter int          BANKGROUP = 0,
  parameter int          BANK      = 0,
  parameter int unsigned NUM_TAGS  = 16,
  parameter int unsigned ID_W      = 32,
  parameter int unsigned CYC_W     = 64,
  parameter int unsigned LAT_W     = 16,
  parameter int unsigned NUM_BINS  = 8,
  parameter int unsigned BIN_SHIFT = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_fire,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [ID_W-1:0]              request_id,
  input  logic                         resp_fire,
  input  logic [ID_W-1:0]              resp_id,
  input  logic [CYC_W-1:0]             globalCycle,
  input  logic                         clear_stats,
  output logic [$clog2(NUM_TAGS):0]    occupancy,
  output logic                         table_full,
  output logic                         lat_valid,
  output logic [LAT_W-1:0]             lat_value,
  output logic                         lat_is_write,
  output logic [CNT_W-1:0]             rd_done_cnt,
  output logic [CNT_W-1:0]             wr_done_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             orphan_cnt,
  output logic [LAT_W-1:0]             lat_min,
  output logic [LAT_W-1:0]             lat_max,
  output logic [CNT_W+LAT_W-1:0]       lat_sum,
  output logic [NUM_BINS*CNT_W-1:0]    hist
);

  localparam int unsigned IDX_W  = $clog2(NUM_TAGS);
  localparam int unsigned OCC_W  = IDX_W + 1;
  localparam int unsigned BIN_W  = (NUM_BINS > 2) ? $clog2(NUM_BINS) : 1;
  localparam int unsigned SUM_W  = CNT_W + LAT_W;
  localparam int unsigned SUM_XW = SUM_W + 1;

  // Elaboration-time configuration sanity check
  if (NUM_TAGS < 2 || (NUM_TAGS & (NUM_TAGS - 1)) != 0 || NUM_BINS < 2 ||
      ID_W > ENTRY_ID_W || CYC_W > ENTRY_CYC_W ||
      RANK < 0 || BANKGROUP < 0 || BANK < 0) begin : g_bad_cfg
    $error("bank_sched_latency_monitor: unsupported parameter set");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  bsm_entry_t         r_tab [NUM_TAGS];
  logic [OCC_W-1:0]   r_occ;
  logic               r_full;
  logic               r_lat_valid;
  logic [LAT_W-1:0]   r_lat_value;
  logic               r_lat_is_write;
  logic [CNT_W-1:0]   r_rd_done;
  logic [CNT_W-1:0]   r_wr_done;
  logic [CNT_W-1:0]   r_drop;
  logic [CNT_W-1:0]   r_orphan;
  logic [LAT_W-1:0]   r_lat_min;
  logic [LAT_W-1:0]   r_lat_max;
  logic [SUM_W-1:0]   r_lat_sum;
  logic [CNT_W-1:0]   r_hist [NUM_BINS];

  logic [NUM_TAGS-1:0] w_free_vec;
  logic [NUM_TAGS-1:0] w_match_vec;
  logic [IDX_W-1:0]    w_free_idx;
  logic [IDX_W-1:0]    w_match_idx;
  logic                w_free_found;
  logic                w_match_found;
  logic                w_alloc;
  logic                w_drop;
  logic                w_hit;
  logic                w_orphan;
  logic                w_is_write;
  logic [CYC_W-1:0]    w_diff;
  logic [LAT_W-1:0]    w_lat;
  logic [BIN_W-1:0]    w_bin;
  logic [OCC_W-1:0]    w_occ_nxt;
  logic [SUM_XW-1:0]   w_sum_ext;
  logic [SUM_W-1:0]    w_sum_nxt;

  // Candidate vectors from pre-edge table state only, so a response can never
  // match the entry being allocated in the same cycle
  always_comb begin
    w_free_vec  = '0;
    w_match_vec = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_free_vec[i]  = ~r_tab[i].valid;
      w_match_vec[i] = r_tab[i].valid && (r_tab[i].id == ENTRY_ID_W'(resp_id));
    end
  end

  bsm_lowest_index #(.N(NUM_TAGS), .W(IDX_W)) u_free_sel (
    .i_vec     (w_free_vec),
    .o_idx_c   (w_free_idx),
    .o_found_c (w_free_found)
  );

  bsm_lowest_index #(.N(NUM_TAGS), .W(IDX_W)) u_match_sel (
    .i_vec     (w_match_vec),
    .o_idx_c   (w_match_idx),
    .o_found_c (w_match_found)
  );

  // Fullness is judged on the registered state, before any same-cycle free
  assign w_alloc    = req_fire && !r_full && w_free_found;
  assign w_drop     = req_fire && r_full;
  assign w_hit      = resp_fire && w_match_found;
  assign w_orphan   = resp_fire && !w_match_found;
  // Both enables set or both clear is a protocol violation, recorded as a read
  assign w_is_write = wr_en & ~rd_en;

  assign w_diff    = globalCycle - CYC_W'(r_tab[w_match_idx].start);
  assign w_lat     = LAT_W'(sat_latency(64'(w_diff), LAT_W));
  assign w_bin     = BIN_W'(bin_index(64'(w_lat), BIN_SHIFT, NUM_BINS));
  assign w_sum_ext = {1'b0, r_lat_sum} + SUM_XW'(w_lat);
  assign w_sum_nxt = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_alloc && !w_hit)      w_occ_nxt = r_occ + OCC_W'(1);
    else if (!w_alloc && w_hit) w_occ_nxt = r_occ - OCC_W'(1);
  end

  // Outstanding-request table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAGS; i++) r_tab[i] <= '0;
    end else begin
      if (w_alloc) begin
        r_tab[w_free_idx].valid    <= 1'b1;
        r_tab[w_free_idx].id       <= ENTRY_ID_W'(request_id);
        r_tab[w_free_idx].is_write <= w_is_write;
        r_tab[w_free_idx].start    <= ENTRY_CYC_W'(globalCycle);
      end
      if (w_hit) r_tab[w_match_idx].valid <= 1'b0;
    end
  end

  // Occupancy and full flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ  <= '0;
      r_full <= 1'b0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_full <= (w_occ_nxt == OCC_W'(NUM_TAGS));
    end
  end

  // Completion pulse; it fires even when the statistics are being cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_valid    <= 1'b0;
      r_lat_value    <= '0;
      r_lat_is_write <= 1'b0;
    end else begin
      r_lat_valid <= w_hit;
      if (w_hit) begin
        r_lat_value    <= w_lat;
        r_lat_is_write <= r_tab[w_match_idx].is_write;
      end
    end
  end

  // Statistics; clear_stats wins over any same-cycle event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_done <= '0;
      r_wr_done <= '0;
      r_drop    <= '0;
      r_orphan  <= '0;
      r_lat_min <= '1;
      r_lat_max <= '0;
      r_lat_sum <= '0;
      for (int b = 0; b < NUM_BINS; b++) r_hist[b] <= '0;
    end else if (clear_stats) begin
      r_rd_done <= '0;
      r_wr_done <= '0;
      r_drop    <= '0;
      r_orphan  <= '0;
      r_lat_min <= '1;
      r_lat_max <= '0;
      r_lat_sum <= '0;
      for (int b = 0; b < NUM_BINS; b++) r_hist[b] <= '0;
    end else begin
      if (w_drop)   r_drop   <= sat_inc(r_drop);
      if (w_orphan) r_orphan <= sat_inc(r_orphan);
      if (w_hit) begin
        if (r_tab[w_match_idx].is_write) r_wr_done <= sat_inc(r_wr_done);
        else                             r_rd_done <= sat_inc(r_rd_done);
        if (w_lat < r_lat_min) r_lat_min <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
        r_lat_sum <= w_sum_nxt;
      end
      for (int b = 0; b < NUM_BINS; b++) begin
        if (w_hit && (w_bin == BIN_W'(b))) r_hist[b] <= sat_inc(r_hist[b]);
      end
    end
  end

  assign occupancy    = r_occ;
  assign table_full   = r_full;
  assign lat_valid    = r_lat_valid;
  assign lat_value    = r_lat_value;
  assign lat_is_write = r_lat_is_write;
  assign rd_done_cnt  = r_rd_done;
  assign wr_done_cnt  = r_wr_done;
  assign drop_cnt     = r_drop;
  assign orphan_cnt   = r_orphan;
  assign lat_min      = r_lat_min;
  assign lat_max      = r_lat_max;
  assign lat_sum      = r_lat_sum;

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_hist
    assign hist[g*CNT_W +: CNT_W] = r_hist[g];
  end

`ifdef STATS_CSV_TRACE_EN
  // Simulation-only event trace, one row per completion, drop or orphan
  initial begin
    $display("latency_stats_rank%0d_bg%0d_bank%0d.csv: %s",
             RANK, BANKGROUP, BANK, CSV_HEADER);
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (w_hit)
        $display("%0d,%s,%0d,%0d,%0d", resp_id,
                 r_tab[w_match_idx].is_write ? "W" : "R",
                 r_tab[w_match_idx].start, globalCycle, w_lat);
      if (w_drop)
        $display("%0d,DROP,%0d,,", request_id, globalCycle);
      if (w_orphan)
        $display("%0d,ORPHAN,,%0d,", resp_id, globalCycle);
    end
  end
`endif

endmodule

// File: tb/tb_bank_sched_latency_monitor.sv
// Self-checking bench for bank_sched_latency_monitor: a directed vector table,
// hand-written corner sequences and randomized traffic, all compared against
// a slot-array reference model built from the behavioural rules.
module tb_bank_sched_latency_monitor;

  localparam int unsigned NT = 16;
  localparam int unsigned IDW = 32;
  localparam int unsigned CYW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned NB = 8;
  localparam int unsigned BS = 3;
  localparam int unsigned CW = 32;

  localparam longint unsigned LMAX = 64'd65535;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;
  localparam longint unsigned SMAX = 64'hFFFF_FFFF_FFFF;

  logic              clk;
  logic              reset_n;
  logic              req_fire, rd_en, wr_en, resp_fire, clear_stats;
  logic [IDW-1:0]    request_id, resp_id;
  logic [CYW-1:0]    globalCycle;
  logic [4:0]        occupancy;
  logic              table_full, lat_valid, lat_is_write;
  logic [LW-1:0]     lat_value, lat_min, lat_max;
  logic [CW-1:0]     rd_done_cnt, wr_done_cnt, drop_cnt, orphan_cnt;
  logic [CW+LW-1:0]  lat_sum;
  logic [NB*CW-1:0]  hist;

  bank_sched_latency_monitor #(
    .RANK(0), .BANKGROUP(0), .BANK(0), .NUM_TAGS(NT), .ID_W(IDW), .CYC_W(CYW),
    .LAT_W(LW), .NUM_BINS(NB), .BIN_SHIFT(BS), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_fire(req_fire), .rd_en(rd_en),
    .wr_en(wr_en), .request_id(request_id), .resp_fire(resp_fire),
    .resp_id(resp_id), .globalCycle(globalCycle), .clear_stats(clear_stats),
    .occupancy(occupancy), .table_full(table_full), .lat_valid(lat_valid),
    .lat_value(lat_value), .lat_is_write(lat_is_write),
    .rd_done_cnt(rd_done_cnt), .wr_done_cnt(wr_done_cnt), .drop_cnt(drop_cnt),
    .orphan_cnt(orphan_cnt), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .hist(hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slots with valid flags, plus plain statistic counters
  bit              m_v  [NT];
  longint unsigned m_id [NT];
  bit              m_w  [NT];
  longint unsigned m_st [NT];
  int unsigned     m_occ;
  longint unsigned m_rd, m_wr, m_drop, m_orph, m_min, m_max, m_sum;
  longint unsigned m_hist [NB];
  bit              m_lv, m_lw;
  longint unsigned m_lval;

  typedef struct {
    int unsigned rq, rd, wr, id, rs, rid, gc, clr;
    int unsigned e_lv, e_lval, e_occ, e_rd, e_orph, e_min, e_max, e_sum;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned sinc(input longint unsigned x, input longint unsigned mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic model_clear_stats();
    m_rd = 0; m_wr = 0; m_drop = 0; m_orph = 0;
    m_min = LMAX; m_max = 0; m_sum = 0;
    for (int b = 0; b < NB; b++) m_hist[b] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_v[i] = 0;
    m_occ = 0;
    m_lv = 0;
    model_clear_stats();
  endtask

  task automatic model_step(input int unsigned rq, rd, wr, id, rs, rid, gc, clr);
    int fi = -1;
    int mi = -1;
    bit full;
    longint unsigned lat;
    int unsigned bin;
    full = (m_occ == NT);
    for (int i = 0; i < NT; i++) begin
      if (!m_v[i] && fi < 0) fi = i;
      if (m_v[i] && m_id[i] == 64'(rid) && mi < 0) mi = i;
    end
    m_lv = 0;
    if (rq != 0) begin
      if (full) m_drop = sinc(m_drop, CMAX);
      else begin
        m_v[fi] = 1; m_id[fi] = 64'(id); m_w[fi] = (wr != 0) && (rd == 0);
        m_st[fi] = 64'(gc); m_occ++;
      end
    end
    if (rs != 0) begin
      if (mi >= 0) begin
        lat = 64'(gc) - m_st[mi];
        if (lat > LMAX) lat = LMAX;
        m_lv = 1; m_lval = lat; m_lw = m_w[mi];
        m_v[mi] = 0; m_occ--;
        if (m_w[mi]) m_wr = sinc(m_wr, CMAX); else m_rd = sinc(m_rd, CMAX);
        if (lat < m_min) m_min = lat;
        if (lat > m_max) m_max = lat;
        m_sum = (m_sum + lat > SMAX) ? SMAX : m_sum + lat;
        bin = 32'(lat / (64'd1 << BS));
        if (bin > NB - 1) bin = NB - 1;
        m_hist[bin] = sinc(m_hist[bin], CMAX);
      end else begin
        m_orph = sinc(m_orph, CMAX);
      end
    end
    if (clr != 0) model_clear_stats();
  endtask

  task automatic check_all();
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    chk("table_full", 64'(table_full), (m_occ == NT) ? 64'd1 : 64'd0);
    chk("lat_valid", 64'(lat_valid), 64'(m_lv));
    if (m_lv) begin
      chk("lat_value", 64'(lat_value), m_lval);
      chk("lat_is_write", 64'(lat_is_write), 64'(m_lw));
    end
    chk("rd_done_cnt", 64'(rd_done_cnt), m_rd);
    chk("wr_done_cnt", 64'(wr_done_cnt), m_wr);
    chk("drop_cnt", 64'(drop_cnt), m_drop);
    chk("orphan_cnt", 64'(orphan_cnt), m_orph);
    chk("lat_min", 64'(lat_min), m_min);
    chk("lat_max", 64'(lat_max), m_max);
    chk("lat_sum", 64'(lat_sum), m_sum);
    for (int b = 0; b < NB; b++) chk($sformatf("hist[%0d]", b), 64'(hist[b*CW +: CW]), m_hist[b]);
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rising edge
  task automatic step(input int unsigned rq, rd, wr, id, rs, rid, gc, clr);
    @(negedge clk);
    req_fire = (rq != 0); rd_en = (rd != 0); wr_en = (wr != 0);
    request_id = id; resp_fire = (rs != 0); resp_id = rid;
    globalCycle = 64'(gc); clear_stats = (clr != 0);
    model_step(rq, rd, wr, id, rs, rid, gc, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    req_fire = 0; rd_en = 0; wr_en = 0; resp_fire = 0; clear_stats = 0;
    request_id = '0; resp_id = '0;
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gcr;
    int unsigned rq, rd, wr, id, rs, rid, clr;

    // req / resp / clr, then expected lat_valid, lat_value, occ, rd_done, orphan, min, max, sum
    vecs[0] = '{1, 1, 0, 5, 0, 0, 100, 0,  0, 0, 1, 0, 0, 65535, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 101, 0,  0, 0, 1, 0, 0, 65535, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 1, 5, 123, 0,  1, 23, 0, 1, 0, 23, 23, 23};
    vecs[3] = '{0, 0, 0, 0, 1, 99, 124, 0, 0, 0, 0, 1, 1, 23, 23, 23};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 125, 0,  0, 0, 0, 1, 1, 23, 23, 23};
    vecs[5] = '{1, 0, 1, 9, 0, 0, 200, 0,  0, 0, 1, 1, 1, 23, 23, 23};
    vecs[6] = '{0, 0, 0, 0, 1, 9, 213, 0,  1, 13, 0, 1, 1, 13, 23, 36};

    reset_n = 0;
    idle_inputs();
    globalCycle = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("reset lat_min", 64'(lat_min), 64'd65535);
    chk("reset occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    reset_n = 1;

    // Directed vector table
    for (int k = 0; k < 7; k++) begin
      step(vecs[k].rq, vecs[k].rd, vecs[k].wr, vecs[k].id, vecs[k].rs,
           vecs[k].rid, vecs[k].gc, vecs[k].clr);
      chk($sformatf("vec%0d lat_valid", k), 64'(lat_valid), 64'(vecs[k].e_lv));
      if (vecs[k].e_lv != 0) chk($sformatf("vec%0d lat_value", k), 64'(lat_value), 64'(vecs[k].e_lval));
      chk($sformatf("vec%0d occupancy", k), 64'(occupancy), 64'(vecs[k].e_occ));
      chk($sformatf("vec%0d rd_done", k), 64'(rd_done_cnt), 64'(vecs[k].e_rd));
      chk($sformatf("vec%0d orphan", k), 64'(orphan_cnt), 64'(vecs[k].e_orph));
      chk($sformatf("vec%0d lat_min", k), 64'(lat_min), 64'(vecs[k].e_min));
      chk($sformatf("vec%0d lat_max", k), 64'(lat_max), 64'(vecs[k].e_max));
      chk($sformatf("vec%0d lat_sum", k), 64'(lat_sum), 64'(vecs[k].e_sum));
    end
    chk("table hist[2]", 64'(hist[2*CW +: CW]), 64'd1);
    chk("table hist[1]", 64'(hist[1*CW +: CW]), 64'd1);
    chk("table wr_done", 64'(wr_done_cnt), 64'd1);

    // Fill the table, overflow it, then req+resp together while full
    step(0, 0, 0, 0, 0, 0, 300, 1);
    for (int k = 0; k < 16; k++) step(1, 1, 0, 100 + k, 0, 0, 301 + k, 0);
    chk("fill table_full", 64'(table_full), 64'd1);
    chk("fill occupancy", 64'(occupancy), 64'd16);
    step(1, 1, 0, 200, 0, 0, 320, 0);
    chk("overflow drop", 64'(drop_cnt), 64'd1);
    chk("overflow occupancy", 64'(occupancy), 64'd16);
    step(1, 1, 0, 201, 1, 100, 330, 0);
    chk("full req+resp drop", 64'(drop_cnt), 64'd2);
    chk("full req+resp occupancy", 64'(occupancy), 64'd15);
    chk("full req+resp lat_value", 64'(lat_value), 64'd29);
    for (int k = 1; k < 16; k++) step(0, 0, 0, 0, 1, 100 + k, 340, 0);
    chk("drain occupancy", 64'(occupancy), 64'd0);

    // Latency saturation into the last bin
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 42, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 42, 70000, 0);
    chk("sat lat_value", 64'(lat_value), 64'd65535);
    chk("sat lat_is_write", 64'(lat_is_write), 64'd1);
    chk("sat hist[7]", 64'(hist[7*CW +: CW]), 64'd1);
    chk("sat wr_done", 64'(wr_done_cnt), 64'd1);

    // Duplicate IDs, clear with a simultaneous completion, same-cycle same-ID
    step(0, 0, 0, 0, 0, 0, 1000, 1);
    step(1, 1, 0, 7, 0, 0, 1010, 0);
    step(1, 1, 0, 7, 0, 0, 1020, 0);
    chk("dup occupancy", 64'(occupancy), 64'd2);
    step(0, 0, 0, 0, 1, 7, 1030, 0);
    chk("dup lowest lat", 64'(lat_value), 64'd20);
    chk("dup occupancy after", 64'(occupancy), 64'd1);
    step(0, 0, 0, 0, 1, 7, 1050, 1);
    chk("clr pulse", 64'(lat_valid), 64'd1);
    chk("clr pulse value", 64'(lat_value), 64'd30);
    chk("clr rd_done", 64'(rd_done_cnt), 64'd0);
    chk("clr sum", 64'(lat_sum), 64'd0);
    chk("clr min", 64'(lat_min), 64'd65535);
    chk("clr hist[3]", 64'(hist[3*CW +: CW]), 64'd0);
    step(1, 1, 0, 8, 1, 8, 1060, 0);
    chk("same-id orphan", 64'(orphan_cnt), 64'd1);
    chk("same-id no pulse", 64'(lat_valid), 64'd0);
    chk("same-id occupancy", 64'(occupancy), 64'd1);
    step(0, 0, 0, 0, 1, 8, 1065, 0);
    chk("same-id later lat", 64'(lat_value), 64'd5);

    // Reset with three requests in flight
    step(1, 1, 0, 1, 0, 0, 2000, 0);
    step(1, 0, 1, 2, 0, 0, 2001, 0);
    step(1, 1, 0, 3, 0, 0, 2002, 0);
    chk("inflight occupancy", 64'(occupancy), 64'd3);
    apply_reset();
    for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, 1, k, 2010 + k, 0);
    chk("post-reset orphans", 64'(orphan_cnt), 64'd3);
    chk("post-reset occupancy", 64'(occupancy), 64'd0);

    // Randomized traffic against the model
    gcr = 3000;
    for (int n = 0; n < 700; n++) begin
      rq  = ($urandom_range(0, 99) < 55) ? 1 : 0;
      rd  = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1);
      id  = $urandom_range(0, 7);
      rs  = ($urandom_range(0, 99) < 45) ? 1 : 0;
      rid = $urandom_range(0, 8);
      clr = ($urandom_range(0, 79) == 0) ? 1 : 0;
      gcr += $urandom_range(0, 30);
      if ($urandom_range(0, 49) == 0) gcr += $urandom_range(60000, 80000);
      if ($urandom_range(0, 299) == 0) apply_reset();
      step(rq, rd, wr, id, rs, rid, gcr, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
